// File: rtl/dds_phase_acc.sv
// Phase-continuous DDS phase accumulator with an AXI-Stream configuration input
// and an AXI-Stream phase-word output; new configs are applied on a sample boundary.
module dds_phase_acc #(
  parameter int PHASE_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_axis_phase_tvalid,
  output logic               s_axis_phase_tready,
  input  logic [63:0]        s_axis_phase_tdata,
  output logic               m_axis_phase_tvalid,
  input  logic               m_axis_phase_tready,
  output logic [PHASE_W-1:0] m_axis_phase_tdata,
  input  logic               run_clr,
  output logic [CNT_W-1:0]   cfg_cnt,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  state_t cur_state, nxt_state;

  logic [PHASE_W-1:0] acc, inc, off;
  logic [PHASE_W-1:0] pend_inc, pend_off;
  logic               pend_valid;
  logic [PHASE_W-1:0] inc_e, off_e;
  logic               advance;
  logic               cfg_hs;

  assign s_axis_phase_tready = !pend_valid && !run_clr;
  assign cfg_hs              = s_axis_phase_tvalid && s_axis_phase_tready;
  assign state               = cur_state;

  assign inc_e = pend_valid ? pend_inc : inc;
  assign off_e = pend_valid ? pend_off : off;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Leaving IDLE performs the first advance in the same cycle, from acc = 0.
  always_comb begin
    nxt_state = cur_state;
    advance   = 1'b0;
    case (cur_state)
      IDLE: begin
        if (pend_valid) begin
          advance   = 1'b1;
          nxt_state = RUN;
        end
      end
      RUN: begin
        advance = !m_axis_phase_tvalid || m_axis_phase_tready;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
    if (run_clr) begin
      advance   = 1'b0;
      nxt_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc                 <= '0;
      inc                 <= '0;
      off                 <= '0;
      pend_inc            <= '0;
      pend_off            <= '0;
      pend_valid          <= 1'b0;
      m_axis_phase_tvalid <= 1'b0;
      m_axis_phase_tdata  <= '0;
      cfg_cnt             <= '0;
    end else if (run_clr) begin
      acc                 <= '0;
      pend_valid          <= 1'b0;
      m_axis_phase_tvalid <= 1'b0;
    end else begin
      if (advance) begin
        m_axis_phase_tdata  <= acc + off_e;
        acc                 <= acc + inc_e;
        inc                 <= inc_e;
        off                 <= off_e;
        m_axis_phase_tvalid <= 1'b1;
      end
      // A handshake can only occur while nothing is pending, so these never collide.
      if (advance && pend_valid) begin
        pend_valid <= 1'b0;
        cfg_cnt    <= cfg_cnt + CNT_W'(1);
      end else if (cfg_hs) begin
        pend_inc   <= s_axis_phase_tdata[PHASE_W-1:0];
        pend_off   <= s_axis_phase_tdata[32 +: PHASE_W];
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_acc.sv
// Self-checking bench for dds_phase_acc: directed scenarios plus randomized
// traffic compared against a sample-stream reference model.
module tb_dds_phase_acc;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_axis_phase_tvalid = 1'b0;
  logic        s_axis_phase_tready;
  logic [63:0] s_axis_phase_tdata = '0;
  logic        m_axis_phase_tvalid;
  logic        m_axis_phase_tready = 1'b0;
  logic [31:0] m_axis_phase_tdata;
  logic        run_clr = 1'b0;
  logic [15:0] cfg_cnt;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  dds_phase_acc #(.PHASE_W(32), .CNT_W(16)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .s_axis_phase_tvalid (s_axis_phase_tvalid),
    .s_axis_phase_tready (s_axis_phase_tready),
    .s_axis_phase_tdata  (s_axis_phase_tdata),
    .m_axis_phase_tvalid (m_axis_phase_tvalid),
    .m_axis_phase_tready (m_axis_phase_tready),
    .m_axis_phase_tdata  (m_axis_phase_tdata),
    .run_clr             (run_clr),
    .cfg_cnt             (cfg_cnt),
    .state               (state)
  );

  always #5 clk = ~clk;

  // Reference model: the phase of each emitted sample is the running phase plus
  // the offset in force; a buffered config takes over at the next emitted sample.
  logic [31:0] ref_phase = '0, ref_step = '0, ref_ofs = '0;
  logic [31:0] ref_next_step = '0, ref_next_ofs = '0;
  logic [31:0] ref_data = '0;
  logic [15:0] ref_cnt = '0;
  bit          ref_buffered = 0, ref_running = 0, ref_valid = 0;
  bit          ref_take, ref_emit;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_phase = '0; ref_step = '0; ref_ofs = '0;
      ref_next_step = '0; ref_next_ofs = '0;
      ref_data = '0; ref_cnt = '0;
      ref_buffered = 0; ref_running = 0; ref_valid = 0;
    end else begin
      ref_take = s_axis_phase_tvalid && !ref_buffered && !run_clr;
      ref_emit = ref_running ? (!ref_valid || m_axis_phase_tready) : ref_buffered;
      if (run_clr) begin
        ref_running = 0; ref_valid = 0; ref_phase = '0; ref_buffered = 0;
      end else begin
        if (ref_emit) begin
          if (ref_buffered) begin
            ref_step = ref_next_step;
            ref_ofs  = ref_next_ofs;
            ref_buffered = 0;
            ref_cnt = ref_cnt + 16'd1;
          end
          ref_data    = ref_phase + ref_ofs;
          ref_phase   = ref_phase + ref_step;
          ref_valid   = 1;
          ref_running = 1;
        end
        if (ref_take) begin
          ref_next_step = s_axis_phase_tdata[31:0];
          ref_next_ofs  = s_axis_phase_tdata[63:32];
          ref_buffered  = 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Entered just after a falling edge; returns just after the falling edge that
  // follows the accepting rising edge, with tvalid dropped.
  task automatic send_cfg(input logic [31:0] inc, input logic [31:0] off);
    bit done = 0;
    bit rdy;
    s_axis_phase_tdata  = {off, inc};
    s_axis_phase_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      rdy = s_axis_phase_tready;
      @(posedge clk);
      @(negedge clk);
      done = rdy;
    end
    s_axis_phase_tvalid = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL cfg_handshake_timeout: got no handshake expected one within 50 cycles");
    end
  endtask

  task automatic pulse_clr();
    run_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_clr = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_axis_phase_tvalid = 1'($urandom);
      s_axis_phase_tdata  = {$urandom, $urandom};
      m_axis_phase_tready = 1'($urandom);
      #1;
      n_tests++;
      if (m_axis_phase_tvalid !== 1'b0 || m_axis_phase_tdata !== 32'h0 ||
          s_axis_phase_tready !== 1'b1 || cfg_cnt !== 16'h0 || state !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_values: got v=%b d=%h rdy=%b cnt=%h st=%h expected v=0 d=0 rdy=1 cnt=0 st=0",
                 m_axis_phase_tvalid, m_axis_phase_tdata, s_axis_phase_tready, cfg_cnt, state);
      end
    end
    @(negedge clk);
    s_axis_phase_tvalid = 1'b0;
    m_axis_phase_tready = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_single_config();
    logic [31:0] exp_d [4] = '{32'h0, 32'h186A0, 32'h30D40, 32'h493E0};
    logic [15:0] base = ref_cnt;
    m_axis_phase_tready = 1'b1;
    send_cfg(32'h186A0, 32'h0);
    n_tests++;
    if (m_axis_phase_tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_first_latency: got valid=%b expected 0 one cycle after handshake",
               m_axis_phase_tvalid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== exp_d[i]) begin
        n_fail++;
        $display("[TB] FAIL single_sample%0d: got v=%b d=%h expected v=1 d=%h",
                 i, m_axis_phase_tvalid, m_axis_phase_tdata, exp_d[i]);
      end
    end
    n_tests++;
    if (cfg_cnt !== base + 16'd1 || state !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL single_cnt_state: got cnt=%h st=%h expected cnt=%h st=1",
               cfg_cnt, state, base + 16'd1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_after [2] = '{32'h300, 32'h400};
    pulse_clr();
    m_axis_phase_tready = 1'b1;
    send_cfg(32'h100, 32'h0);
    repeat (3) @(negedge clk);
    m_axis_phase_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== 32'h200) begin
        n_fail++;
        $display("[TB] FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=00000200",
                 i, m_axis_phase_tvalid, m_axis_phase_tdata);
      end
      if (i < 5) @(negedge clk);
    end
    m_axis_phase_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== exp_after[i]) begin
        n_fail++;
        $display("[TB] FAIL bp_resume%0d: got d=%h expected d=%h", i, m_axis_phase_tdata, exp_after[i]);
      end
    end
  endtask

  task automatic test_phase_step();
    logic [15:0] base;
    pulse_clr();
    base = ref_cnt;
    m_axis_phase_tready = 1'b1;
    send_cfg(32'h100, 32'h0);
    repeat (3) @(negedge clk);
    m_axis_phase_tready = 1'b0;
    send_cfg(32'h200, 32'h10);
    n_tests++;
    if (m_axis_phase_tdata !== 32'h200 || cfg_cnt !== base + 16'd1) begin
      n_fail++;
      $display("[TB] FAIL step_before: got d=%h cnt=%h expected d=00000200 cnt=%h",
               m_axis_phase_tdata, cfg_cnt, base + 16'd1);
    end
    m_axis_phase_tready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (m_axis_phase_tdata !== 32'h310 || cfg_cnt !== base + 16'd2) begin
      n_fail++;
      $display("[TB] FAIL step_first: got d=%h cnt=%h expected d=00000310 cnt=%h",
               m_axis_phase_tdata, cfg_cnt, base + 16'd2);
    end
    @(negedge clk);
    n_tests++;
    if (m_axis_phase_tdata !== 32'h510) begin
      n_fail++;
      $display("[TB] FAIL step_second: got d=%h expected d=00000510", m_axis_phase_tdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    pulse_clr();
    base = ref_cnt;
    m_axis_phase_tready = 1'b1;
    s_axis_phase_tvalid = 1'b1;
    s_axis_phase_tdata  = {32'hFFFFFFFF, 32'h80000000};
    @(posedge clk);
    @(negedge clk);
    s_axis_phase_tdata = {32'hFFFFFFFF, 32'h00000001};
    #1;
    n_tests++;
    if (s_axis_phase_tready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_ready_low: got rdy=%b expected 0 while first config pending", s_axis_phase_tready);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (s_axis_phase_tready !== 1'b1 || m_axis_phase_tdata !== 32'hFFFFFFFF || m_axis_phase_tvalid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_sample0: got rdy=%b v=%b d=%h expected rdy=1 v=1 d=ffffffff",
               s_axis_phase_tready, m_axis_phase_tvalid, m_axis_phase_tdata);
    end
    @(posedge clk);
    @(negedge clk);
    s_axis_phase_tvalid = 1'b0;
    n_tests++;
    if (s_axis_phase_tready !== 1'b0 || m_axis_phase_tdata !== 32'h7FFFFFFF) begin
      n_fail++;
      $display("[TB] FAIL b2b_sample1: got rdy=%b d=%h expected rdy=0 d=7fffffff",
               s_axis_phase_tready, m_axis_phase_tdata);
    end
    @(negedge clk);
    n_tests++;
    if (m_axis_phase_tdata !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("[TB] FAIL b2b_sample2: got d=%h expected d=ffffffff", m_axis_phase_tdata);
    end
    @(negedge clk);
    n_tests++;
    if (m_axis_phase_tdata !== 32'h0 || cfg_cnt !== base + 16'd2) begin
      n_fail++;
      $display("[TB] FAIL b2b_sample3: got d=%h cnt=%h expected d=00000000 cnt=%h",
               m_axis_phase_tdata, cfg_cnt, base + 16'd2);
    end
  endtask

  task automatic test_run_clr();
    logic [15:0] base;
    pulse_clr();
    base = ref_cnt;
    m_axis_phase_tready = 1'b1;
    send_cfg(32'h40, 32'h1000);
    repeat (2) @(negedge clk);
    m_axis_phase_tready = 1'b0;
    send_cfg(32'h5000, 32'h7);
    pulse_clr();
    #1;
    n_tests++;
    if (m_axis_phase_tvalid !== 1'b0 || state !== 2'd0 || s_axis_phase_tready !== 1'b1 ||
        cfg_cnt !== base + 16'd1) begin
      n_fail++;
      $display("[TB] FAIL clr_effect: got v=%b st=%h rdy=%b cnt=%h expected v=0 st=0 rdy=1 cnt=%h",
               m_axis_phase_tvalid, state, s_axis_phase_tready, cfg_cnt, base + 16'd1);
    end
    @(negedge clk);
    n_tests++;
    if (m_axis_phase_tvalid !== 1'b0 || state !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL clr_pending_dropped: got v=%b st=%h expected v=0 st=0", m_axis_phase_tvalid, state);
    end
    m_axis_phase_tready = 1'b1;
    send_cfg(32'h2222, 32'h10);
    @(negedge clk);
    n_tests++;
    if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== 32'h10) begin
      n_fail++;
      $display("[TB] FAIL clr_restart0: got v=%b d=%h expected v=1 d=00000010", m_axis_phase_tvalid, m_axis_phase_tdata);
    end
    @(negedge clk);
    n_tests++;
    if (m_axis_phase_tdata !== 32'h2232) begin
      n_fail++;
      $display("[TB] FAIL clr_restart1: got d=%h expected d=00002232", m_axis_phase_tdata);
    end
  endtask

  task automatic test_async_reset();
    pulse_clr();
    m_axis_phase_tready = 1'b1;
    send_cfg(32'h1234, 32'h55);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if (m_axis_phase_tvalid !== 1'b0 || m_axis_phase_tdata !== 32'h0 || cfg_cnt !== 16'h0 ||
        state !== 2'd0 || s_axis_phase_tready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got v=%b d=%h cnt=%h st=%h rdy=%b expected v=0 d=0 cnt=0 st=0 rdy=1",
               m_axis_phase_tvalid, m_axis_phase_tdata, cfg_cnt, state, s_axis_phase_tready);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] r_inc;
    logic        exp_rdy;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_tests++;
      if (m_axis_phase_tvalid !== ref_valid || m_axis_phase_tdata !== ref_data ||
          cfg_cnt !== ref_cnt || state !== (ref_running ? 2'd1 : 2'd0)) begin
        n_fail++;
        $display("[TB] FAIL random_out cycle %0d: got v=%b d=%h cnt=%h st=%h expected v=%b d=%h cnt=%h st=%0d",
                 i, m_axis_phase_tvalid, m_axis_phase_tdata, cfg_cnt, state,
                 ref_valid, ref_data, ref_cnt, ref_running);
      end
      r_inc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 4096)) : $urandom;
      s_axis_phase_tvalid = ($urandom_range(0, 2) == 0);
      s_axis_phase_tdata  = {$urandom, r_inc};
      m_axis_phase_tready = ($urandom_range(0, 3) != 0);
      run_clr             = ($urandom_range(0, 39) == 0);
      #1;
      exp_rdy = !ref_buffered && !run_clr;
      n_tests++;
      if (s_axis_phase_tready !== exp_rdy) begin
        n_fail++;
        $display("[TB] FAIL random_ready cycle %0d: got rdy=%b expected rdy=%b", i, s_axis_phase_tready, exp_rdy);
      end
    end
    @(negedge clk);
    s_axis_phase_tvalid = 1'b0;
    run_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_config();
    test_backpressure();
    test_phase_step();
    test_back_to_back();
    test_run_clr();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
